isa_io_cycle_ctrl: RTL and testbench

Sequences single ISA I/O read and write cycles on behalf of the HPS and sits directly upstream of the ISA bus interface stage. It accepts one command at a time over a valid/ready handshake and drives the address/data values and load pulses that the bus interface registers. It also generates the active-low IOR/IOW strobes and AEN with programmable setup, strobe and hold timing. Read data is sampled from the ISA data bus and returned with a one-cycle response pulse.

---
 rtl/isa_bus_pkg.sv | 27 ++
 rtl/isa_io_cycle_ctrl_if.sv | 38 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/isa_io_cycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_isa_io_cycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_bus_pkg.sv
// Shared definitions for the ISA I/O cycle controller slice: bus widths,
// the cycle-sequencer state encoding and the value returned by a timed-out read.
package isa_bus_pkg;

  localparam int ISA_ADDR_W = 16;
  localparam int ISA_DATA_W = 16;

  // Read data reported when IOCHRDY never returns within the timeout window
  localparam logic [ISA_DATA_W-1:0] ISA_TIMEOUT_RDATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } isa_state_e;

  // Largest of the three phase lengths; sizes the shared phase down-counter
  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/isa_io_cycle_ctrl_if.sv
// HPS command/response handshake plus the ISA-side strobes and bus-interface
// load signals of the I/O cycle controller.
// slave  : the cycle controller itself.
// master : the HPS / ISA environment that issues commands and drives the pins.
interface isa_io_cycle_ctrl_if;
  import isa_bus_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ISA_ADDR_W-1:0] cmd_addr;
  logic [ISA_DATA_W-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [ISA_DATA_W-1:0] rsp_rdata;
  logic                  rsp_timeout;
  logic [ISA_ADDR_W-1:0] address_HPS;
  logic [ISA_DATA_W-1:0] data_HPS;
  logic                  address_load;
  logic                  data_load;
  logic                  IOW;
  logic                  IOR;
  logic                  AEN;
  logic                  iochrdy;
  logic [ISA_DATA_W-1:0] isa_data;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, iochrdy, isa_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output address_HPS, data_HPS, address_load, data_load, IOW, IOR, AEN
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, iochrdy, isa_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  address_HPS, data_HPS, address_load, data_load, IOW, IOR, AEN
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (IOCHRDY).
// Output lags the input pin by two clk cycles; resets to 0 (not ready).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Shift the pin level through two flops to settle metastability
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/isa_io_cycle_ctrl.sv
// ISA I/O cycle controller: accepts one HPS command at a time and sequences
// SETUP -> STROBE [-> WAIT] -> HOLD -> DONE, driving AEN, IOR/IOW and the
// address/data load pulses for the downstream bus interface stage.
// Optional feature macro: ISA_IOCHRDY_EN (IOCHRDY wait states + timeout).
// Without it, every cycle has fixed length and rsp_timeout is always 0.
module isa_io_cycle_ctrl
  import isa_bus_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int STROBE_CYCLES  = 8,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  isa_io_cycle_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(max_of3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  isa_state_e            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  write_r;
  logic                  timeout_r;
  logic [ISA_ADDR_W-1:0] address_r;
  logic [ISA_DATA_W-1:0] data_r;
  logic                  address_load_r;
  logic                  data_load_r;
  logic                  iow_r;
  logic                  ior_r;
  logic                  aen_r;
  logic                  cmd_ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_timeout_r;
  logic [ISA_DATA_W-1:0] rsp_rdata_r;

`ifdef ISA_IOCHRDY_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO   = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE    = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(TIMEOUT_CYCLES);

  logic              rdy_sync_s;
  logic [WAIT_W-1:0] wait_cnt_r;

  sync_2ff u_iochrdy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.iochrdy),
    .q     (rdy_sync_s)
  );
`else
  // IOCHRDY and the timeout length have no effect in the fixed-length build
  localparam int unused_timeout_cycles_p = TIMEOUT_CYCLES;
  logic unused_iochrdy_s;
  assign unused_iochrdy_s = bus.iochrdy;
`endif

  // Cycle sequencer: state, phase counter and every registered bus output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= CNT_ZERO;
      write_r        <= 1'b0;
      timeout_r      <= 1'b0;
      address_r      <= {ISA_ADDR_W{1'b0}};
      data_r         <= {ISA_DATA_W{1'b0}};
      address_load_r <= 1'b0;
      data_load_r    <= 1'b0;
      iow_r          <= 1'b1;
      ior_r          <= 1'b1;
      aen_r          <= 1'b1;
      cmd_ready_r    <= 1'b0;
      rsp_valid_r    <= 1'b0;
      rsp_timeout_r  <= 1'b0;
      rsp_rdata_r    <= {ISA_DATA_W{1'b0}};
`ifdef ISA_IOCHRDY_EN
      wait_cnt_r     <= WAIT_ZERO;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          timeout_r     <= 1'b0;
          rsp_timeout_r <= 1'b0;
          if (bus.cmd_valid && cmd_ready_r) begin
            address_r      <= bus.cmd_addr;
            data_r         <= bus.cmd_wdata;
            write_r        <= bus.cmd_write;
            cmd_ready_r    <= 1'b0;
            aen_r          <= 1'b0;
            address_load_r <= 1'b1;
            data_load_r    <= bus.cmd_write;
            cnt_r          <= SETUP_LOAD;
            state_r        <= ST_SETUP;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end

        ST_SETUP: begin
          address_load_r <= 1'b0;
          data_load_r    <= 1'b0;
          if (cnt_r == CNT_ZERO) begin
            // Only the strobe matching the latched direction goes low
            iow_r   <= ~write_r;
            ior_r   <= write_r;
            cnt_r   <= STROBE_LOAD;
            state_r <= ST_STROBE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_STROBE: begin
          if (cnt_r == CNT_ZERO) begin
            if (!write_r) begin
              rsp_rdata_r <= bus.isa_data;
            end
`ifdef ISA_IOCHRDY_EN
            if (rdy_sync_s) begin
              iow_r   <= 1'b1;
              ior_r   <= 1'b1;
              cnt_r   <= HOLD_LOAD;
              state_r <= ST_HOLD;
            end else begin
              // Device is stretching the cycle; keep the strobe low
              wait_cnt_r <= WAIT_ONE;
              state_r    <= ST_WAIT;
            end
`else
            iow_r   <= 1'b1;
            ior_r   <= 1'b1;
            cnt_r   <= HOLD_LOAD;
            state_r <= ST_HOLD;
`endif
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

`ifdef ISA_IOCHRDY_EN
        ST_WAIT: begin
          if (rdy_sync_s) begin
            if (!write_r) begin
              rsp_rdata_r <= bus.isa_data;
            end
            iow_r   <= 1'b1;
            ior_r   <= 1'b1;
            cnt_r   <= HOLD_LOAD;
            state_r <= ST_HOLD;
          end else if (wait_cnt_r == WAIT_LIMIT) begin
            // Device never became ready: abandon the cycle with a flagged result
            timeout_r <= 1'b1;
            if (!write_r) begin
              rsp_rdata_r <= ISA_TIMEOUT_RDATA;
            end
            iow_r   <= 1'b1;
            ior_r   <= 1'b1;
            cnt_r   <= HOLD_LOAD;
            state_r <= ST_HOLD;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
`endif

        ST_HOLD: begin
          if (cnt_r == CNT_ZERO) begin
            aen_r         <= 1'b1;
            rsp_valid_r   <= 1'b1;
            rsp_timeout_r <= timeout_r;
            state_r       <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        ST_DONE: begin
          rsp_valid_r   <= 1'b0;
          rsp_timeout_r <= 1'b0;
          timeout_r     <= 1'b0;
          cmd_ready_r   <= 1'b1;
          state_r       <= ST_IDLE;
        end

        default: begin
          // Unreachable encoding: fall back to a safe idle bus
          iow_r          <= 1'b1;
          ior_r          <= 1'b1;
          aen_r          <= 1'b1;
          address_load_r <= 1'b0;
          data_load_r    <= 1'b0;
          rsp_valid_r    <= 1'b0;
          rsp_timeout_r  <= 1'b0;
          cmd_ready_r    <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_r;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_rdata    = rsp_rdata_r;
  assign bus.rsp_timeout  = rsp_timeout_r;
  assign bus.address_HPS  = address_r;
  assign bus.data_HPS     = data_r;
  assign bus.address_load = address_load_r;
  assign bus.data_load    = data_load_r;
  assign bus.IOW          = iow_r;
  assign bus.IOR          = ior_r;
  assign bus.AEN          = aen_r;

endmodule

// File: tb/tb_isa_io_cycle_ctrl.sv
// Directed bench for isa_io_cycle_ctrl with a response scoreboard.
// Inputs change 2ns after the rising edge; outputs are sampled on the falling edge.
module tb_isa_io_cycle_ctrl;

  typedef struct {
    logic        write;
    logic [15:0] rdata;
    logic        timeout;
    int          latency;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  int   accept_count;
  int   prev_acc;
  bit   b2b_mode;
  exp_t exp_q[$];
  int   acc_q[$];

  isa_io_cycle_ctrl_if bus ();

  isa_io_cycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ISA_IOCHRDY_EN
  isa_io_cycle_ctrl_if bus_to ();

  isa_io_cycle_ctrl #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_to)
  );
`endif

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to time-stamp acceptances and responses
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Continuous protocol checks and scoreboard pops on every falling edge
  always @(negedge clk) begin
    exp_t e;
    int   t0;
    if (reset === 1'b0) begin
      check("strobe_excl", {31'd0, (bus.IOR === 1'b0 && bus.IOW === 1'b0)}, 32'd0);
      if (bus.cmd_ready === 1'b1) check("aen_idle", {31'd0, bus.AEN}, 32'd1);
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        if (b2b_mode && prev_acc >= 0) check("b2b_period", 32'(cyc - prev_acc), 32'd14);
        prev_acc = cyc;
        acc_q.push_back(cyc);
        accept_count++;
      end
      if (bus.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          t0 = acc_q.pop_front();
          check("rsp_latency", 32'(cyc - t0), 32'(e.latency));
          check("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, e.timeout});
          if (!e.write) check("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, e.rdata});
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.cmd_ready !== 1'b1 && n < 60);
    check("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // Push the expectation, then present one command for exactly one cycle
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rdata, input logic exp_to, input int lat);
    exp_t e;
    wait_ready();
    e.write = wr; e.rdata = exp_rdata; e.timeout = exp_to; e.latency = lat;
    exp_q.push_back(e);
    @(posedge clk); #2;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
  endtask

  // Expected waveform for a fixed-length cycle, offsets T0+1..T0+13
  task automatic profile(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    logic [5:0] exp_w;
    logic [5:0] obs_w;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_w[5] = (k == 1);
      exp_w[4] = (k == 1) && wr;
      exp_w[3] = (k > 12);
      exp_w[2] = !(wr && k >= 3 && k <= 10);
      exp_w[1] = !(!wr && k >= 3 && k <= 10);
      exp_w[0] = (k == 13);
      obs_w = {bus.address_load, bus.data_load, bus.AEN, bus.IOW, bus.IOR, bus.rsp_valid};
      check($sformatf("wave_t%0d", k), {26'd0, obs_w}, {26'd0, exp_w});
      if (k == 1 || k == 12) begin
        check($sformatf("addr_t%0d", k), {16'd0, bus.address_HPS}, {16'd0, addr});
        check($sformatf("data_t%0d", k), {16'd0, bus.data_HPS}, {16'd0, wdata});
      end
    end
  endtask

  // Directed test sequence
  initial begin
    int n;
    int low_cnt;
    bit seen;
    cyc = 0; checks = 0; failures = 0; accept_count = 0; prev_acc = -1; b2b_mode = 1'b0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0000;
    bus.cmd_wdata = 16'h0000; bus.iochrdy = 1'b1; bus.isa_data = 16'h0000;
`ifdef ISA_IOCHRDY_EN
    bus_to.cmd_valid = 1'b0; bus_to.cmd_write = 1'b0; bus_to.cmd_addr = 16'h0330;
    bus_to.cmd_wdata = 16'h0000; bus_to.iochrdy = 1'b0; bus_to.isa_data = 16'h00AA;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes_aen", {29'd0, bus.IOW, bus.IOR, bus.AEN}, 32'd7);
    check("rst_pulses", {27'd0, bus.address_load, bus.data_load, bus.rsp_valid,
                         bus.rsp_timeout, bus.cmd_ready}, 32'd0);
    check("rst_regs", {bus.address_HPS, bus.data_HPS}, 32'd0);
    check("rst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Write 0x0220 <- 0xA55A
    issue(1'b1, 16'h0220, 16'hA55A, 16'h0000, 1'b0, 13);
    profile(1'b1, 16'h0220, 16'hA55A);

    // Read 0x022A, data 0x00AA on the bus
    bus.isa_data = 16'h00AA;
    issue(1'b0, 16'h022A, 16'hBEEF, 16'h00AA, 1'b0, 13);
    profile(1'b0, 16'h022A, 16'hBEEF);

    // Write with extreme address/data values
    issue(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 13);
    profile(1'b1, 16'hFFFF, 16'h0001);

`ifdef ISA_IOCHRDY_EN
    // IOCHRDY low for 20 cycles across the strobe end; data changes during the wait
    bus.isa_data = 16'h1111;
    issue(1'b0, 16'h0300, 16'h0000, 16'h2222, 1'b0, 30);
    low_cnt = 0;
    for (int k = 1; k <= 35; k++) begin
      if (k == 5)  bus.iochrdy = 1'b0;
      if (k == 20) bus.isa_data = 16'h2222;
      if (k == 25) bus.iochrdy = 1'b1;
      @(negedge clk);
      if (bus.IOR === 1'b0) low_cnt++;
      @(posedge clk); #2;
    end
    check("wait_ior_low_cycles", 32'(low_cnt), 32'd25);

    // IOCHRDY stuck low on the short-timeout instance
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_to.cmd_ready !== 1'b1 && n < 60);
    check("to_ready_wait", {31'd0, bus_to.cmd_ready}, 32'd1);
    @(posedge clk); #2;
    bus_to.cmd_valid = 1'b1;
    @(posedge clk); #2;
    bus_to.cmd_valid = 1'b0;
    low_cnt = 0; n = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (bus_to.IOR === 1'b0) low_cnt++;
      if (bus_to.rsp_valid === 1'b1) begin
        n = k;
        check("to_rsp_timeout", {31'd0, bus_to.rsp_timeout}, 32'd1);
        check("to_rsp_rdata", {16'd0, bus_to.rsp_rdata}, 32'h0000FFFF);
      end
      @(posedge clk); #2;
    end
    check("to_ior_low_cycles", 32'(low_cnt), 32'd24);
    check("to_rsp_offset", 32'(n), 32'd29);
`endif

    // Reset during STROBE
    issue(1'b1, 16'h0310, 16'h1234, 16'h0000, 1'b0, 13);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_iow_low", {31'd0, bus.IOW}, 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_strobes_aen", {29'd0, bus.IOW, bus.IOR, bus.AEN}, 32'd7);
    check("midrst_pulses", {29'd0, bus.address_load, bus.data_load, bus.rsp_valid}, 32'd0);
    check("midrst_regs", {bus.address_HPS, bus.rsp_rdata}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("rel_ready_high", {31'd0, bus.cmd_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    check("no_rsp_after_abort", {31'd0, seen}, 32'd0);

    // cmd_valid held high: three reads accepted 14 cycles apart
    bus.isa_data = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.write = 1'b0; e.rdata = 16'h5A5A; e.timeout = 1'b0; e.latency = 13;
      exp_q.push_back(e);
    end
    wait_ready();
    b2b_mode = 1'b1;
    prev_acc = -1;
    n = accept_count;
    @(posedge clk); #2;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h0240;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 100 && accept_count < n + 3; k++) begin
      @(posedge clk); #2;
    end
    bus.cmd_valid = 1'b0;
    check("b2b_accepts", 32'(accept_count - n), 32'd3);

    // Drain outstanding responses
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      @(negedge clk);
    end
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
